// File: rtl/if_id_stage.sv
// IF stage program counter and IF/ID pipeline register with load-use hazard detection.
// Optional stall-cycle counter enabled by defining PERF_CNT_EN; otherwise stall_count reads 0.
module if_id_stage #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        idexmemread,
  input  logic [4:0]  idexrd,
  output logic [63:0] pc_out,
  output logic [63:0] ifidpc_out,
  output logic [31:0] ifidinst,
  output logic        ifidvalid,
  output logic        stall,
  output logic        flush_idex,
  output logic [31:0] stall_count
);

  logic [63:0] pc_q, pc_d;
  logic [63:0] ifidpc_q, ifidpc_d;
  logic [31:0] ifidinst_q, ifidinst_d;
  logic        ifidvalid_q, ifidvalid_d;

  logic [4:0]  ifid_rs1;
  logic [4:0]  ifid_rs2;
  logic        hazard;
  logic [63:0] target_aligned;

  assign ifid_rs1       = ifidinst_q[19:15];
  assign ifid_rs2       = ifidinst_q[24:20];
  assign target_aligned = branch_target & ~64'h3;

  // A flushed IF/ID slot holds no real instruction, so it can never be a hazard source.
  always_comb begin
    hazard = ifidvalid_q && idexmemread && (idexrd != 5'd0) &&
             ((idexrd == ifid_rs1) || (idexrd == ifid_rs2));
    stall      = hazard && !branch_taken;
    flush_idex = branch_taken || hazard;
  end

  always_comb begin
    pc_d        = pc_q;
    ifidpc_d    = ifidpc_q;
    ifidinst_d  = ifidinst_q;
    ifidvalid_d = ifidvalid_q;
    if (branch_taken) begin
      pc_d        = target_aligned;
      ifidpc_d    = 64'h0;
      ifidinst_d  = NOP_INST;
      ifidvalid_d = 1'b0;
    end else if (!stall) begin
      pc_d        = pc_q + 64'd4;
      ifidpc_d    = pc_q;
      ifidinst_d  = instruction;
      ifidvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      ifidpc_q    <= 64'h0;
      ifidinst_q  <= NOP_INST;
      ifidvalid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      ifidpc_q    <= ifidpc_d;
      ifidinst_q  <= ifidinst_d;
      ifidvalid_q <= ifidvalid_d;
    end
  end

  assign pc_out     = pc_q;
  assign ifidpc_out = ifidpc_q;
  assign ifidinst   = ifidinst_q;
  assign ifidvalid  = ifidvalid_q;

`ifdef PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= 32'h0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: stimulus pushes per-cycle expectations, a monitor pops
// and compares registered state plus the combinational stall/flush outputs.
module tb_if_id_stage;

`ifdef PERF_CNT_EN
  localparam bit Perf = 1'b1;
`else
  localparam bit Perf = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        idexmemread;
  logic [4:0]  idexrd;
  logic [63:0] pc_out;
  logic [63:0] ifidpc_out;
  logic [31:0] ifidinst;
  logic        ifidvalid;
  logic        stall;
  logic        flush_idex;
  logic [31:0] stall_count;

  if_id_stage dut (
    .clk           (clk),
    .reset         (reset),
    .instruction   (instruction),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .idexmemread   (idexmemread),
    .idexrd        (idexrd),
    .pc_out        (pc_out),
    .ifidpc_out    (ifidpc_out),
    .ifidinst      (ifidinst),
    .ifidvalid     (ifidvalid),
    .stall         (stall),
    .flush_idex    (flush_idex),
    .stall_count   (stall_count)
  );

  typedef struct {
    string       name;
    logic [63:0] pc;
    logic [63:0] ipc;
    logic [31:0] inst;
    logic        valid;
    logic        st;
    logic        fl;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input string field, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %h, expected %h", name, field, act, req);
    end
  endtask

  // Monitor: sample after the stimulus has settled for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk(e.name, "pc_out", pc_out, e.pc);
        chk(e.name, "ifidpc_out", ifidpc_out, e.ipc);
        chk(e.name, "ifidinst", {32'h0, ifidinst}, {32'h0, e.inst});
        chk(e.name, "ifidvalid", {63'h0, ifidvalid}, {63'h0, e.valid});
        chk(e.name, "stall", {63'h0, stall}, {63'h0, e.st});
        chk(e.name, "flush_idex", {63'h0, flush_idex}, {63'h0, e.fl});
        chk(e.name, "stall_count", {32'h0, stall_count}, {32'h0, e.cnt});
      end
    end
  end

  // Drive one cycle's inputs and record what the DUT should show during that cycle:
  // state left by the previous edge, and stall/flush for these inputs.
  task automatic cyc(input string name, input logic rst, input logic br,
                     input logic [63:0] tgt, input logic mr, input logic [4:0] rd,
                     input logic [31:0] ins, input logic [63:0] e_pc,
                     input logic [63:0] e_ipc, input logic [31:0] e_inst,
                     input logic e_v, input logic e_st, input logic e_fl,
                     input logic [31:0] e_cnt);
    exp_t e;
    @(negedge clk);
    #1;
    reset         = rst;
    branch_taken  = br;
    branch_target = tgt;
    idexmemread   = mr;
    idexrd        = rd;
    instruction   = ins;
    e.name  = name;
    e.pc    = e_pc;
    e.ipc   = e_ipc;
    e.inst  = e_inst;
    e.valid = e_v;
    e.st    = e_st;
    e.fl    = e_fl;
    e.cnt   = Perf ? e_cnt : 32'h0;
    exp_q.push_back(e);
  endtask

  localparam logic [31:0] Nop  = 32'h00000013;
  localparam logic [63:0] PcTop = 64'hFFFF_FFFF_FFFF_FFFC;

  initial begin
    int budget;
    reset         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 64'h0;
    idexmemread   = 1'b0;
    idexrd        = 5'd0;
    instruction   = 32'h0;

    //   name          rst br tgt            mr rd    instr          pc      ifidpc  ifidinst   v st fl cnt
    cyc("reset_a",     0, 0, 64'h0,          0, 5'd0, 32'h0,        64'h0,   64'h0,  Nop,          0, 0, 0, 0);
    cyc("release",     1, 0, 64'h0,          0, 5'd0, 32'h00500093, 64'h0,   64'h0,  Nop,          0, 0, 0, 0);
    cyc("first_fetch", 1, 0, 64'h0,          0, 5'd0, 32'h002081B3, 64'h4,   64'h0,  32'h00500093, 1, 0, 0, 0);
    cyc("loaduse_rs2", 1, 0, 64'h0,          1, 5'd2, 32'h00000033, 64'h8,   64'h4,  32'h002081B3, 1, 1, 1, 0);
    cyc("rd_zero",     1, 0, 64'h0,          1, 5'd0, 32'h00000033, 64'h8,   64'h4,  32'h002081B3, 1, 0, 0, 1);
    cyc("no_match",    1, 0, 64'h0,          1, 5'd5, 32'h00018113, 64'hC,   64'h8,  32'h00000033, 1, 0, 0, 1);
    cyc("br_hazard",   1, 1, 64'h107,        1, 5'd3, 32'h00000033, 64'h10,  64'hC,  32'h00018113, 1, 0, 1, 1);
    cyc("flushed",     1, 0, 64'h0,          1, 5'd3, 32'h00018113, 64'h104, 64'h0,  Nop,          0, 0, 0, 1);
    cyc("loaduse_rs1", 1, 0, 64'h0,          1, 5'd3, 32'h00000033, 64'h108, 64'h104, 32'h00018113, 1, 1, 1, 1);
    cyc("rst_in_stall",0, 1, 64'h200,        1, 5'd3, 32'h00000033, 64'h108, 64'h104, 32'h00018113, 1, 0, 1, 2);
    cyc("after_rst",   1, 0, 64'h0,          1, 5'd3, 32'h00500093, 64'h0,   64'h0,  Nop,          0, 0, 0, 0);
    cyc("br_top",      1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 5'd0, 32'h00000033, 64'h4, 64'h0, 32'h00500093, 1, 0, 1, 0);
    cyc("at_top",      1, 0, 64'h0,          0, 5'd0, 32'h00000033, PcTop,   64'h0,  Nop,          0, 0, 0, 0);
    cyc("wrapped",     1, 0, 64'h0,          0, 5'd0, 32'h00100093, 64'h0,   PcTop,  32'h00000033, 1, 0, 0, 0);
    cyc("post_wrap",   1, 0, 64'h0,          0, 5'd0, 32'h00000013, 64'h4,   64'h0,  32'h00100093, 1, 0, 0, 0);

    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0, PC value loaded on reset.
REQ-002 Parameter NOP_INST, default 32'h00000013, instruction word inserted on flush/reset.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-low reset; 0 at posedge clk resets the block.
REQ-005 instruction  in  32  instruction-memory read data for address pc_out.
REQ-006 branch_taken  in  1  EX-stage branch resolved taken.
REQ-007 branch_target  in  64  EX-stage branch target address.
REQ-008 idexmemread  in  1  memread of instruction currently in ID/EX.
REQ-009 idexrd  in  5  rd of instruction currently in ID/EX.
REQ-010 pc_out  out  64  fetch address driven to instruction memory.
REQ-011 ifidpc_out  out  64  PC of instruction held in IF/ID.
REQ-012 ifidinst  out  32  instruction held in IF/ID.
REQ-013 ifidvalid  out  1  IF/ID holds a real instruction.
REQ-014 stall  out  1  load-use hazard; ID must inject zero control into ID/EX.
REQ-015 flush_idex  out  1  ID/EX must load zero control next edge.
REQ-016 stall_count  out  32  stall-cycle counter (PERF_CNT_EN only).

Function
REQ-017 Hazard (combinational): hazard = ifidvalid & idexmemread & (idexrd != 0) & (idexrd == ifidinst[19:15] | idexrd == ifidinst[24:20]).
REQ-018 stall = hazard & ~branch_taken; flush_idex = branch_taken | hazard.
REQ-019 Priority per edge when reset=1: branch_taken > stall > normal.
REQ-020 Branch: pc_out <= {branch_target[63:2],2'b00}; ifidinst <= NOP_INST; ifidvalid <= 0; ifidpc_out <= 0.
REQ-021 Stall: pc_out, ifidpc_out, ifidinst, ifidvalid hold.
REQ-022 Normal: pc_out <= pc_out + 4 (64-bit wrap, 64'hFFFF_FFFF_FFFF_FFFC -> 0); ifidpc_out <= pc_out; ifidinst <= instruction; ifidvalid <= 1.
REQ-023 Latency: instruction fetched at pc_out appears on ifidinst one cycle later.
REQ-024 Stall lasts exactly one cycle per load-use pair, since ID/EX receives a bubble (idexmemread=0) next cycle.
REQ-025 Branch and hazard in same cycle: branch wins, no stall, stall_count unchanged.
REQ-026 Flushed IF/ID (ifidvalid=0) never raises hazard, even if NOP_INST fields match idexrd.
REQ-027 Outputs pc_out, ifid* are registered; stall and flush_idex are combinational.

Reset
REQ-028 reset=0 at posedge: pc_out=RESET_PC, ifidpc_out=0, ifidinst=NOP_INST, ifidvalid=0, stall_count=0.
REQ-029 Reset overrides branch_taken and hazard in the same cycle; mid-stall reset clears state with no residual stall.
REQ-030 First cycle after reset release: IF/ID loads instruction at RESET_PC, pc_out=RESET_PC+4.

Configuration
REQ-031 Macro PERF_CNT_EN defined: stall_count increments by 1 on every edge with stall=1, saturates at 32'hFFFF_FFFF, cleared only by reset.
REQ-032 PERF_CNT_EN undefined: no counter register; stall_count tied to 0; all other behaviour identical.

Verification
REQ-033 reset=0 two cycles, release, instruction=32'h00500093 -> next edge ifidinst=32'h00500093, ifidpc_out=0, pc_out=8 at following edge.
REQ-034 ifidinst=32'h002081B3 (rs1=1,rs2=2), idexmemread=1, idexrd=2 -> stall=1, flush_idex=1, pc_out/IF/ID held one cycle; stall_count 0->1.
REQ-035 Same as REQ-034 with idexrd=0 -> stall=0, pipeline advances.
REQ-036 branch_taken=1, branch_target=64'h107, with hazard active -> stall=0, flush_idex=1, pc_out=64'h104, ifidinst=32'h00000013, ifidvalid=0, stall_count unchanged.
REQ-037 pc_out=64'hFFFF_FFFF_FFFF_FFFC, normal advance -> pc_out=0.
REQ-038 reset=0 asserted during stall with branch_taken=1 -> pc_out=RESET_PC, ifidvalid=0, stall_count=0.
